lin_frame_rx: RTL

LIN_FRAME_RX -- requirements
Module: lin_frame_rx

---
 rtl/lin_pkg.sv | 33 +++
 rtl/lin_byte_rx.sv | 76 +++++++
 rtl/lin_frame_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lin_pkg.sv
// rtl/lin_pkg.sv - shared LIN receiver types, constants and helpers

package lin_pkg;

  typedef enum logic [2:0] {
    IDLE, BREAK, DELIM, SYNC, PID, DATA, CHKSUM, DONE
  } lin_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam int         BREAK_MIN = 13;

  localparam int ERR_FRAMING  = 0;
  localparam int ERR_SYNC     = 1;
  localparam int ERR_PARITY   = 2;
  localparam int ERR_CHECKSUM = 3;
  localparam int ERR_TIMEOUT  = 4;

  function automatic logic [7:0] pid_protect(input logic [5:0] id);
    logic p0;
    logic p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  // 8-bit add with the carry folded back into bit 0
  function automatic logic [7:0] add_eac(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

endpackage

// File: rtl/lin_byte_rx.sv
// rtl/lin_byte_rx.sv - LIN bit timing, start detect and 10-bit byte framing

module lin_byte_rx #(
  parameter int BIT_CYCLES = 1
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       sdi_i,
  input  logic       free_run_i,
  output logic       bit_tick_o,
  output logic       bit_o,
  output logic       start_o,
  output logic       byte_done_o,
  output logic [7:0] byte_o,
  output logic       stop_err_o
);

  localparam int             CW     = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0]  HALF_C = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0]  LAST_C = CW'(BIT_CYCLES - 1);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          line_q;

  logic          active;
  logic [CW-1:0] phase;
  logic [3:0]    cur_idx;

  // a start is a falling edge seen while hunting; that cycle is phase 0 of bit 0
  assign start_o     = !run_q && line_q && !sdi_i;
  assign active      = run_q || start_o;
  assign phase       = run_q ? cnt_q : '0;
  assign cur_idx     = run_q ? idx_q : 4'd0;
  assign bit_tick_o  = active && (phase == HALF_C);
  assign bit_o       = sdi_i;
  assign byte_done_o = bit_tick_o && !free_run_i && (cur_idx == 4'd9);
  assign stop_err_o  = byte_done_o && !sdi_i;
  assign byte_o      = shreg_q;

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (active) begin
      run_d = 1'b1;
      cnt_d = (phase == LAST_C) ? '0 : phase + CW'(1);
      idx_d = (phase == LAST_C) ? cur_idx + 4'd1 : cur_idx;
      if (bit_tick_o) begin
        if (cur_idx != 4'd0 && cur_idx <= 4'd8) shreg_d = {sdi_i, shreg_q[7:1]};
        // free-run keeps the bit grid through a long break until the line goes recessive
        if (free_run_i ? sdi_i : (cur_idx == 4'd9)) run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      shreg_q <= 8'd0;
      line_q  <= 1'b1;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      line_q  <= sdi_i;
    end
  end

endmodule

// File: rtl/lin_frame_rx.sv
// rtl/lin_frame_rx.sv - LIN frame receiver: break/sync/PID/data/checksum decode

module lin_frame_rx import lin_pkg::*; #(
  parameter int BIT_CYCLES   = 1,
  parameter int ENHANCED     = 0,
  parameter int IDLE_TIMEOUT = 14
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        sdi,
  output logic [5:0]  pid,
  output logic [63:0] data,
  output logic        frame_valid,
  output logic [4:0]  err,
  output logic        busy
);

  localparam int            TO_CYCLES = IDLE_TIMEOUT * BIT_CYCLES;
  localparam int            TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  lin_state_e      state_q;
  logic [4:0]      brk_cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      sum_q;
  logic            to_run_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [5:0]      pid_buf_q;
  logic [63:0]     buf_q;
  logic [5:0]      pid_q;
  logic [63:0]     data_q;
  logic            frame_valid_q;
  logic [4:0]      err_q;

  logic       bit_tick, bit_val, start, byte_done, stop_err;
  logic [7:0] rx_byte;

  lin_byte_rx #(.BIT_CYCLES(BIT_CYCLES)) u_byte_rx (
    .sys_clk_i   (sys_clk),
    .rst_i       (rst),
    .sdi_i       (sdi),
    .free_run_i  (state_q == BREAK),
    .bit_tick_o  (bit_tick),
    .bit_o       (bit_val),
    .start_o     (start),
    .byte_done_o (byte_done),
    .byte_o      (rx_byte),
    .stop_err_o  (stop_err)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      brk_cnt_q     <= 5'd0;
      idx_q         <= 3'd0;
      sum_q         <= 8'd0;
      to_run_q      <= 1'b0;
      to_cnt_q      <= '0;
      pid_buf_q     <= 6'd0;
      buf_q         <= 64'd0;
      pid_q         <= 6'd0;
      data_q        <= 64'd0;
      frame_valid_q <= 1'b0;
      err_q         <= 5'd0;
    end else begin
      frame_valid_q <= 1'b0;
      err_q         <= 5'd0;
      case (state_q)
        IDLE: if (bit_tick && !bit_val) begin
          state_q   <= BREAK;
          brk_cnt_q <= 5'd1;
        end
        BREAK: if (bit_tick) begin
          if (!bit_val) begin
            if (brk_cnt_q != 5'd31) brk_cnt_q <= brk_cnt_q + 5'd1;
          end else begin
            state_q <= (brk_cnt_q >= 5'(BREAK_MIN)) ? DELIM : IDLE;
          end
        end
        DELIM: if (bit_tick && !bit_val) state_q <= SYNC;
        SYNC: if (byte_done) begin
          if (stop_err) begin
            err_q[ERR_FRAMING] <= 1'b1;
            state_q            <= IDLE;
          end else if (rx_byte != SYNC_BYTE) begin
            err_q[ERR_SYNC] <= 1'b1;
            state_q         <= IDLE;
          end else begin
            state_q  <= PID;
            to_run_q <= 1'b1;
            to_cnt_q <= '0;
          end
        end
        PID: if (byte_done) begin
          if (stop_err) begin
            err_q[ERR_FRAMING] <= 1'b1;
            state_q            <= IDLE;
          end else if (rx_byte != pid_protect(rx_byte[5:0])) begin
            err_q[ERR_PARITY] <= 1'b1;
            state_q           <= IDLE;
          end else begin
            pid_buf_q <= rx_byte[5:0];
            sum_q     <= (ENHANCED != 0) ? rx_byte : 8'd0;
            idx_q     <= 3'd0;
            state_q   <= DATA;
            to_run_q  <= 1'b1;
            to_cnt_q  <= '0;
          end
        end
        DATA: if (byte_done) begin
          if (stop_err) begin
            err_q[ERR_FRAMING] <= 1'b1;
            state_q            <= IDLE;
          end else begin
            buf_q[{idx_q, 3'b000} +: 8] <= rx_byte;
            sum_q    <= add_eac(sum_q, rx_byte);
            idx_q    <= idx_q + 3'd1;
            to_run_q <= 1'b1;
            to_cnt_q <= '0;
            if (idx_q == 3'd7) state_q <= CHKSUM;
          end
        end
        CHKSUM: if (byte_done) begin
          if (stop_err) begin
            err_q[ERR_FRAMING] <= 1'b1;
            state_q            <= IDLE;
          end else if (rx_byte != ~sum_q) begin
            err_q[ERR_CHECKSUM] <= 1'b1;
            state_q             <= IDLE;
          end else begin
            frame_valid_q <= 1'b1;
            pid_q         <= pid_buf_q;
            data_q        <= buf_q;
            state_q       <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // inter-byte gap watchdog; only armed while hunting for the next start bit
      if (to_run_q) begin
        if (start) begin
          to_run_q <= 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          err_q[ERR_TIMEOUT] <= 1'b1;
          state_q            <= IDLE;
          to_run_q           <= 1'b0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign pid         = pid_q;
  assign data        = data_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);

endmodule
